// File: rtl/dm_arb_pkg.sv
// Shared definitions for the two-port data memory arbiter:
// FSM state encoding, owner encoding and default widths.
package dm_arb_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCK_B = 1'b1
    } arb_state_e;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;
    localparam int LOCK_CNT_W = 8;

endpackage

// File: rtl/dm_rr_arbiter2.sv
// Two-way grant decision: a lone requester always wins; on contention either
// A wins outright (priority mode) or the port that did not own last wins.
module dm_rr_arbiter2
    import dm_arb_pkg::*;
#(
    parameter bit A_PRIORITY = 1'b0
) (
    input  logic i_a_req,
    input  logic i_b_req,
    input  logic i_last_owner,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    always_comb begin
        o_gnt_a = 1'b0;
        o_gnt_b = 1'b0;
        if (i_a_req && i_b_req) begin
            if (A_PRIORITY || (i_last_owner == OWN_B)) begin
                o_gnt_a = 1'b1;
            end else begin
                o_gnt_b = 1'b1;
            end
        end else begin
            o_gnt_a = i_a_req;
            o_gnt_b = i_b_req;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares a single-port data memory between the MEM stage (A) and a loader (B),
// one access per cycle, with an optional bounded B lock burst.
//   state  | meaning
//   ARB    | normal two-way arbitration each cycle
//   LOCK_B | B holds ownership while b_lock; A is forced in after MAX_LOCK waits
module data_memory_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_LOCK   = 8,
    parameter int A_PRIORITY = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_a_req,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    output logic              o_a_gnt,
    output logic              o_a_rvalid,
    output logic [DATA_W-1:0] o_a_rdata,
    input  logic              i_b_req,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    input  logic              i_b_lock,
    output logic              o_b_gnt,
    output logic              o_b_rvalid,
    output logic [DATA_W-1:0] o_b_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [LOCK_CNT_W-1:0] MAX_LOCK_C = LOCK_CNT_W'(MAX_LOCK);

    arb_state_e            r_state;
    logic [LOCK_CNT_W-1:0] r_lock_cnt;
    logic                  r_last_owner;
    logic                  r_a_rvalid;
    logic                  r_b_rvalid;

    arb_state_e            w_state_nxt;
    logic [LOCK_CNT_W-1:0] w_lock_cnt_nxt;
    logic                  w_rr_a;
    logic                  w_rr_b;
    logic                  w_gnt_a;
    logic                  w_gnt_b;

    dm_rr_arbiter2 #(
        .A_PRIORITY (A_PRIORITY != 0)
    ) u_rr (
        .i_a_req      (i_a_req),
        .i_b_req      (i_b_req),
        .i_last_owner (r_last_owner),
        .o_gnt_a      (w_rr_a),
        .o_gnt_b      (w_rr_b)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ARB;
            r_lock_cnt   <= '0;
            r_last_owner <= OWN_B;
            r_a_rvalid   <= 1'b0;
            r_b_rvalid   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            if (w_gnt_a) begin
                r_last_owner <= OWN_A;
            end else if (w_gnt_b) begin
                r_last_owner <= OWN_B;
            end
            r_a_rvalid <= w_gnt_a & ~i_a_we;
            r_b_rvalid <= w_gnt_b & ~i_b_we;
        end
    end

    // A dropped lock or B request falls back to plain arbitration this cycle.
    always_comb begin
        w_gnt_a        = w_rr_a;
        w_gnt_b        = w_rr_b;
        w_state_nxt    = ARB;
        w_lock_cnt_nxt = '0;
        if ((r_state == LOCK_B) && i_b_req && i_b_lock) begin
            if (i_a_req && (r_lock_cnt >= MAX_LOCK_C)) begin
                w_gnt_a = 1'b1;
                w_gnt_b = 1'b0;
            end else begin
                w_gnt_a     = 1'b0;
                w_gnt_b     = 1'b1;
                w_state_nxt = LOCK_B;
                if (i_a_req && (r_lock_cnt < MAX_LOCK_C)) begin
                    w_lock_cnt_nxt = r_lock_cnt + 1'b1;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt;
                end
            end
        end else if (w_rr_b && i_b_lock) begin
            w_state_nxt    = LOCK_B;
            w_lock_cnt_nxt = LOCK_CNT_W'(1);
        end
    end

    always_comb begin
        o_a_gnt     = w_gnt_a;
        o_b_gnt     = w_gnt_b;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        if (w_gnt_a) begin
            o_mem_addr  = i_a_addr;
            o_mem_wdata = i_a_wdata;
            o_mem_read  = ~i_a_we;
            o_mem_write = i_a_we;
        end else if (w_gnt_b) begin
            o_mem_addr  = i_b_addr;
            o_mem_wdata = i_b_wdata;
            o_mem_read  = ~i_b_we;
            o_mem_write = i_b_we;
        end
        o_a_rvalid = r_a_rvalid;
        o_b_rvalid = r_b_rvalid;
        o_a_rdata  = r_a_rvalid ? i_mem_rdata : '0;
        o_b_rdata  = r_b_rvalid ? i_mem_rdata : '0;
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: behavioural grant model plus a
// shadow memory predict every grant and every read return.
module tb_data_memory_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int ML = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req, a_we, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, mem_read, mem_write;
    logic [DW-1:0] a_rdata, b_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          p_a_gnt, p_a_rvalid, p_b_gnt, p_b_rvalid, p_mem_read, p_mem_write;
    logic [DW-1:0] p_a_rdata, p_b_rdata, p_mem_wdata;
    logic [AW-1:0] p_mem_addr;

    always #5 clk = ~clk;

    data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML), .A_PRIORITY(0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .i_b_lock(b_lock), .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_read(mem_read),
        .o_mem_write(mem_write), .i_mem_rdata(mem_rdata));

    data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML), .A_PRIORITY(1)) u_dut_pri (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_gnt(p_a_gnt), .o_a_rvalid(p_a_rvalid), .o_a_rdata(p_a_rdata),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .i_b_lock(b_lock), .o_b_gnt(p_b_gnt), .o_b_rvalid(p_b_rvalid), .o_b_rdata(p_b_rdata),
        .o_mem_addr(p_mem_addr), .o_mem_wdata(p_mem_wdata), .o_mem_read(p_mem_read),
        .o_mem_write(p_mem_write), .i_mem_rdata(mem_rdata));

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [DW-1:0] mem    [64];
    logic [DW-1:0] shadow [64];

    // Memory device: registered read on posedge, write on negedge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_read) mem_rdata <= mem[mem_addr];
    end
    always @(negedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state: who owned last, whether B holds a burst, A-wait count.
    int  m_last = 1;
    bit  m_locked = 1'b0;
    int  m_cnt = 0;
    bit  m_ga = 1'b0, m_gb = 1'b0;
    bit  ga, gb;

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t q[$];

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last = 1; m_locked = 1'b0; m_cnt = 0;
            m_ga = 1'b0; m_gb = 1'b0;
            q.delete();
        end else begin
            ga = 1'b0; gb = 1'b0;
            if (m_locked && b_req && b_lock) begin
                if (a_req && m_cnt == ML) begin
                    ga = 1'b1; m_locked = 1'b0; m_cnt = 0;
                end else begin
                    gb = 1'b1;
                    if (a_req && m_cnt < ML) m_cnt++;
                end
            end else begin
                if (a_req && b_req) begin
                    if (m_last == 1) ga = 1'b1; else gb = 1'b1;
                end else begin
                    ga = a_req; gb = b_req;
                end
                m_locked = 1'b0; m_cnt = 0;
                if (gb && b_lock) begin m_locked = 1'b1; m_cnt = 1; end
            end
            chk("a_gnt", a_gnt, ga);
            chk("b_gnt", b_gnt, gb);
            if (ga) begin
                chk("mem_addr_a", mem_addr, a_addr);
                chk("mem_wdata_a", mem_wdata, a_wdata);
                chk("mem_rw_a", {mem_read, mem_write}, {~a_we, a_we});
                m_last = 0;
                if (a_we) shadow[a_addr] = a_wdata;
                else q.push_back('{port: 1'b0, data: shadow[a_addr], due: cyc + 1});
            end else if (gb) begin
                chk("mem_addr_b", mem_addr, b_addr);
                chk("mem_wdata_b", mem_wdata, b_wdata);
                chk("mem_rw_b", {mem_read, mem_write}, {~b_we, b_we});
                m_last = 1;
                if (b_we) shadow[b_addr] = b_wdata;
                else q.push_back('{port: 1'b1, data: shadow[b_addr], due: cyc + 1});
            end else begin
                chk("mem_idle", {mem_read, mem_write, mem_addr, mem_wdata}, '0);
            end
            m_ga = ga; m_gb = gb;
        end
    end

    // Read-return monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                total++; bad++;
                $display("FAIL rvalid_missing: port %0d got no rvalid, required at cycle %0d", q[0].port, q[0].due);
                void'(q.pop_front());
            end
            if (a_rvalid || b_rvalid) begin
                if (q.size() == 0 || q[0].due != cyc) begin
                    total++; bad++;
                    $display("FAIL rvalid_unexpected: got a=%0b b=%0b required none (cycle %0d)", a_rvalid, b_rvalid, cyc);
                end else begin
                    e = q.pop_front();
                    chk("rvalid_pair", {a_rvalid, b_rvalid}, {~e.port, e.port});
                    chk("rdata", e.port ? b_rdata : a_rdata, e.data);
                    chk("rdata_other", e.port ? a_rdata : b_rdata, 0);
                end
            end else begin
                chk("rdata_idle", {a_rdata, b_rdata}, 0);
            end
        end
    end

    task automatic idle();
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_lock = 0;
    endtask

    task automatic to_check(); @(negedge clk); #1; endtask
    task automatic to_drive(); @(posedge clk); #1; endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        to_drive(); to_drive();
        rst_n = 1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {a_gnt, b_gnt, p_a_gnt, p_b_gnt}, 0);
        chk({tag, "_rvalid"}, {a_rvalid, b_rvalid}, 0);
        chk({tag, "_rdata"}, {a_rdata, b_rdata}, 0);
        chk({tag, "_mem"}, {mem_read, mem_write, mem_addr, mem_wdata}, 0);
    endtask

    bit a_pend, b_pend;

    initial begin
        for (int i = 0; i < 64; i++) begin
            logic [DW-1:0] v;
            v = $urandom;
            mem[i] = v; shadow[i] = v;
        end
        mem[5] = 32'hDEAD_BEEF; shadow[5] = 32'hDEAD_BEEF;
        idle();
        to_drive(); to_drive();
        chk_all_zero("reset");
        rst_n = 1;
        to_drive();

        // A read of address 5 straight out of reset.
        a_req = 1; a_addr = 6'd5;
        to_check();
        chk("t1_gnt", {a_gnt, mem_read, mem_addr}, {1'b1, 1'b1, 6'd5});
        to_drive(); idle();
        to_check();
        chk("t1_rvalid", {a_rvalid, b_rvalid}, 2'b10);
        chk("t1_rdata", a_rdata, 32'hDEAD_BEEF);
        to_drive();

        // Continuous contention: A reads, B writes, grants alternate A,B,...
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k == 0 || m_ga) begin a_we = 0; a_addr = 6'($urandom_range(0, 63)); end
            if (k == 0 || m_gb) begin
                b_we = 1; b_addr = 6'($urandom_range(0, 63)); b_wdata = $urandom;
            end
            a_req = 1; b_req = 1;
            to_check();
            chk("rr_alt", {a_gnt, b_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (b_gnt) chk("rr_bwrite", {mem_write, mem_addr}, {1'b1, b_addr});
            to_drive();
        end

        // Priority-mode instance: A wins contention, B gets in when A idles.
        do_reset();
        a_req = 1; a_addr = 6'd3; b_req = 1; b_addr = 6'd4;
        for (int k = 0; k < 4; k++) begin
            to_check();
            chk("pri_gnt", {p_a_gnt, p_b_gnt}, 2'b10);
            chk("pri_mem", {p_mem_read, p_mem_write, p_mem_addr, p_mem_wdata}, {1'b1, 1'b0, 6'd3, a_wdata});
            if (k > 0) begin
                chk("pri_rvalid", {p_a_rvalid, p_b_rvalid}, 2'b10);
                chk("pri_rdata", {p_a_rdata, p_b_rdata}, {mem_rdata, 32'd0});
            end
            to_drive();
        end
        a_req = 0;
        to_check();
        chk("pri_b_after", {p_a_gnt, p_b_gnt}, 2'b01);
        to_drive();

        // Locked B burst with A waiting throughout: A, 8xB, A, then B again in ARB.
        do_reset();
        a_req = 1; a_addr = 6'd1; b_req = 1; b_lock = 1; b_addr = 6'd2;
        for (int k = 0; k < 11; k++) begin
            to_check();
            chk("lock_seq", {a_gnt, b_gnt}, (k == 0 || k == 9) ? 2'b10 : 2'b01);
            to_drive();
        end
        idle();
        to_drive();

        // Read-after-write on consecutive grants.
        b_req = 1; b_we = 1; b_addr = 6'd10; b_wdata = 32'h1234;
        to_check();
        chk("raw_bgnt", b_gnt, 1);
        to_drive(); idle();
        a_req = 1; a_addr = 6'd10;
        to_check();
        chk("raw_agnt", a_gnt, 1);
        to_drive(); idle();
        to_check();
        chk("raw_rdata", {a_rvalid, a_rdata}, {1'b1, 32'h1234});
        to_drive();

        // Reset during an outstanding read.
        a_req = 1; a_addr = 6'd5;
        to_check();
        chk("mid_gnt", a_gnt, 1);
        #1; rst_n = 0; idle();
        to_drive();
        chk_all_zero("mid_rst");
        to_drive();
        chk_all_zero("mid_rst2");
        rst_n = 1;
        a_req = 1; a_addr = 6'd7; b_req = 1; b_addr = 6'd8;
        to_check();
        chk("post_rst_gnt", {a_gnt, b_gnt}, 2'b10);
        to_drive();
        idle();
        to_drive();

        // Randomized traffic; a requester holds its fields until granted.
        a_pend = 0; b_pend = 0;
        for (int n = 0; n < 3000; n++) begin
            if (m_ga) a_pend = 0;
            if (m_gb) b_pend = 0;
            if (!a_pend && $urandom_range(0, 99) < 60) begin
                a_pend = 1; a_we = 1'($urandom_range(0, 1));
                a_addr = 6'($urandom_range(0, 63)); a_wdata = $urandom;
            end
            if (!b_pend && $urandom_range(0, 99) < 70) begin
                b_pend = 1; b_we = 1'($urandom_range(0, 1));
                b_addr = 6'($urandom_range(0, 63)); b_wdata = $urandom;
            end
            a_req = a_pend; b_req = b_pend;
            b_lock = ($urandom_range(0, 3) != 0);
            to_drive();
        end
        idle();
        repeat (3) to_drive();
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
